// File: rtl/shifter_pkg.sv
// Shared types, defaults and helpers for the pipelined barrel shifter.
package shifter_pkg;

   localparam int unsigned DEFAULT_WIDTH   = 64;
   localparam int unsigned DEFAULT_SHAMT_W = 6;

   // Operation encoding as seen on in_op.
   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_SRA = 2'b10,
      SHIFT_ROR = 2'b11
   } shift_op_e;

   // What a right-shift layer puts into the vacated upper bits.
   typedef enum logic [1:0] {
      FILL_ZERO = 2'b00,
      FILL_SIGN = 2'b01,
      FILL_ROT  = 2'b10
   } fill_e;

   // Number of register stages: ceil(shamt_w / pipe_every).
   function automatic int unsigned calc_nstg(input int unsigned shamt_w,
                                             input int unsigned pipe_every);
      return (shamt_w + pipe_every - 1) / pipe_every;
   endfunction

   // SLL runs as a zero-fill right shift on bit-reversed data.
   function automatic fill_e fill_of(input shift_op_e op);
      case (op)
         SHIFT_SRA: return FILL_SIGN;
         SHIFT_ROR: return FILL_ROT;
         default:   return FILL_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_layer.sv
// One mux column: optionally shifts right by DIST with the selected fill.
module shift_layer
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DIST  = 1
) (
   input  logic [WIDTH-1:0] din,
   input  logic             sel,
   input  fill_e            fill,
   input  logic             sign,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] shifted;

   // Right shift by DIST, then overwrite the vacated bits per fill mode.
   always_comb begin
      shifted = din >> DIST;
      case (fill)
         FILL_SIGN: shifted[WIDTH-1 -: DIST] = {DIST{sign}};
         FILL_ROT:  shifted[WIDTH-1 -: DIST] = din[DIST-1:0];
         default:   ;
      endcase
      dout = sel ? shifted : din;
   end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR over SHAMT_W mux layers,
// registered every PIPE_EVERY layers behind a valid/ready handshake.
// Optional macro SHIFTER_WORD_OP_EN adds in_word (RV64 *W ops, WIDTH=64 only).
module pipelined_barrel_shifter
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH      = DEFAULT_WIDTH,
   parameter int unsigned SHAMT_W    = $clog2(WIDTH),
   parameter int unsigned PIPE_EVERY = 2,
   parameter int unsigned TAG_W      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
`ifdef SHIFTER_WORD_OP_EN
   input  logic               in_word,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int unsigned NSTG = calc_nstg(SHAMT_W, PIPE_EVERY);
   localparam int unsigned LAST = NSTG - 1;

   // Elaboration-time parameter checks.
   if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 8");
   end
   if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt
      $error("pipelined_barrel_shifter: SHAMT_W must equal clog2(WIDTH)");
   end
   if (PIPE_EVERY < 1 || PIPE_EVERY > SHAMT_W) begin : g_bad_pipe
      $error("pipelined_barrel_shifter: PIPE_EVERY must be in 1..SHAMT_W");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $error("pipelined_barrel_shifter: TAG_W must be at least 1");
   end
`ifdef SHIFTER_WORD_OP_EN
   if (WIDTH != 64) begin : g_bad_word
      $error("pipelined_barrel_shifter: word ops require WIDTH == 64");
   end
`endif

   function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < int'(WIDTH); i++) r[i] = x[WIDTH-1-i];
      return r;
   endfunction

   logic [NSTG-1:0]    vld_q;
   logic [NSTG-1:0]    adv;
   logic [NSTG-1:0]    ld;
   logic               hole;
   logic               in_fire;

   logic [WIDTH-1:0]   pre_data;
   logic [SHAMT_W-1:0] pre_shamt;
   shift_op_e          pre_op;
   logic               pre_sign;
`ifdef SHIFTER_WORD_OP_EN
   logic               pre_word;
`endif

   // Operand conditioning: reverse for SLL; narrow to 32 bits for word ops.
   always_comb begin
      pre_op    = shift_op_e'(in_op);
      pre_data  = (pre_op == SHIFT_SLL) ? bitrev(in_data) : in_data;
      pre_sign  = in_data[WIDTH-1];
      pre_shamt = in_shamt;
`ifdef SHIFTER_WORD_OP_EN
      pre_word  = in_word;
      if (in_word) begin
         case (pre_op)
            SHIFT_SLL: pre_data = bitrev({32'd0, in_data[31:0]});
            SHIFT_SRA: pre_data = {{32{in_data[31]}}, in_data[31:0]};
            SHIFT_ROR: pre_data = {in_data[31:0], in_data[31:0]};
            default:   pre_data = {32'd0, in_data[31:0]};
         endcase
         pre_sign  = in_data[31];
         pre_shamt = {1'b0, in_shamt[4:0]};
      end
`endif
   end

   // Stage s moves on when full and some stage ahead is empty or the sink is ready.
   always_comb begin
      hole = out_ready;
      adv  = '0;
      for (int s = int'(LAST); s >= 0; s--) begin
         adv[s] = vld_q[s] && hole;
         hole   = hole || !vld_q[s];
      end
      in_ready = hole;
   end

   assign in_fire = in_valid && in_ready;

   // Stage load strobes: stage 0 from the input, others from the stage behind.
   always_comb begin
      ld    = '0;
      ld[0] = in_fire;
      for (int s = 1; s < int'(NSTG); s++) ld[s] = adv[s-1];
   end

   // Valid bits: set on load, cleared when the occupant leaves without a refill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else begin
         for (int s = 0; s < int'(NSTG); s++) begin
            if (ld[s])       vld_q[s] <= 1'b1;
            else if (adv[s]) vld_q[s] <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < int'(NSTG); g++) begin : g_stg
      localparam int unsigned REM_W = SHAMT_W - g * PIPE_EVERY;

      logic [WIDTH-1:0] stg_in;
      logic [WIDTH-1:0] stg_res;
      logic [REM_W-1:0] rem;
      shift_op_e        stg_op;
      logic             stg_sgn;
      logic [TAG_W-1:0] stg_tag;
      logic [WIDTH-1:0] dat_q;
      logic [TAG_W-1:0] tag_q;
`ifdef SHIFTER_WORD_OP_EN
      logic             stg_word;
`endif

      if (g == 0) begin : g_src_in
         assign stg_in  = pre_data;
         assign rem     = pre_shamt;
         assign stg_op  = pre_op;
         assign stg_sgn = pre_sign;
         assign stg_tag = in_tag;
`ifdef SHIFTER_WORD_OP_EN
         assign stg_word = pre_word;
`endif
      end else begin : g_src_reg
         assign stg_in  = g_stg[g-1].dat_q;
         assign rem     = g_stg[g-1].g_ctl.rem_q;
         assign stg_op  = g_stg[g-1].g_ctl.op_q;
         assign stg_sgn = g_stg[g-1].g_ctl.sgn_q;
         assign stg_tag = g_stg[g-1].tag_q;
`ifdef SHIFTER_WORD_OP_EN
         assign stg_word = g_stg[g-1].g_ctl.word_q;
`endif
      end

      for (genvar j = 0; j < int'(PIPE_EVERY); j++) begin : g_lay
         localparam int unsigned K = g * PIPE_EVERY + j;
         logic [WIDTH-1:0] d;
         logic [WIDTH-1:0] q;

         if (j == 0) begin : g_first
            assign d = stg_in;
         end else begin : g_next
            assign d = g_lay[j-1].q;
         end

         if (j < int'(REM_W)) begin : g_mux
            shift_layer #(
               .WIDTH (WIDTH),
               .DIST  (32'd1 << K)
            ) u_layer (
               .din  (d),
               .sel  (rem[j]),
               .fill (fill_of(stg_op)),
               .sign (stg_sgn),
               .dout (q)
            );
         end else begin : g_pass
            assign q = d;
         end
      end

      if (g == int'(LAST)) begin : g_post
         // Undo the SLL reversal; word results sign-extend from bit 31.
         always_comb begin
            stg_res = g_lay[PIPE_EVERY-1].q;
            if (stg_op == SHIFT_SLL) stg_res = bitrev(stg_res);
`ifdef SHIFTER_WORD_OP_EN
            if (stg_word) stg_res = {{(WIDTH-32){stg_res[31]}}, stg_res[31:0]};
`endif
         end
      end else begin : g_mid
         assign stg_res = g_lay[PIPE_EVERY-1].q;

         logic [REM_W-PIPE_EVERY-1:0] rem_q;
         shift_op_e                   op_q;
         logic                        sgn_q;
`ifdef SHIFTER_WORD_OP_EN
         logic                        word_q;
`endif
      end

      // Payload register; holds while the stage is stalled.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dat_q <= '0;
            tag_q <= '0;
         end else if (ld[g]) begin
            dat_q <= stg_res;
            tag_q <= stg_tag;
         end
      end

      if (g != int'(LAST)) begin : g_ctl
         logic [REM_W-PIPE_EVERY-1:0] rem_q;
         shift_op_e                   op_q;
         logic                        sgn_q;
`ifdef SHIFTER_WORD_OP_EN
         logic                        word_q;
`endif

         // Control for the layers still ahead: unused shamt bits, op, sign.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rem_q  <= '0;
               op_q   <= SHIFT_SLL;
               sgn_q  <= 1'b0;
`ifdef SHIFTER_WORD_OP_EN
               word_q <= 1'b0;
`endif
            end else if (ld[g]) begin
               rem_q  <= rem[REM_W-1:PIPE_EVERY];
               op_q   <= stg_op;
               sgn_q  <= stg_sgn;
`ifdef SHIFTER_WORD_OP_EN
               word_q <= stg_word;
`endif
            end
         end
      end
   end

   assign out_valid = vld_q[LAST];
   assign out_data  = g_stg[LAST].dat_q;
   assign out_tag   = g_stg[LAST].tag_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (default parameters).
module tb_pipelined_barrel_shifter;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [5:0]  in_shamt;
   logic [1:0]  in_op;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [3:0]  out_tag;
`ifdef SHIFTER_WORD_OP_EN
   logic        in_word;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] exp_d [$];
   logic [3:0]  exp_t [$];
   logic [63:0] bp_exp [8];

   pipelined_barrel_shifter u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .in_tag    (in_tag),
`ifdef SHIFTER_WORD_OP_EN
      .in_word   (in_word),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [63:0] d, input logic [5:0] s,
                        input logic [1:0] op, input logic [3:0] tag);
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      in_op    = op;
      in_tag   = tag;
   endtask

   // Independent reference built from language shift operators.
   function automatic logic [63:0] ref_shift(input logic [63:0] d, input logic [5:0] s,
                                             input logic [1:0] op);
      case (op)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return 64'($signed(d) >>> s);
         default: return (s == 6'd0) ? d : ((d >> s) | (d << (7'd64 - {1'b0, s})));
      endcase
   endfunction

   // One op on an empty pipe: latency 3, then result and tag.
   task automatic single(input string name, input logic [63:0] d, input logic [5:0] s,
                         input logic [1:0] op, input logic [3:0] tag,
                         input logic [63:0] exp);
      drive(d, s, op, tag);
      #1;
      check({name, "/ready"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      in_data  = '1;
      #1;
      check({name, "/lat1"}, 64'(out_valid), 64'd0);
      tick();
      check({name, "/lat2"}, 64'(out_valid), 64'd0);
      tick();
      check({name, "/valid"}, 64'(out_valid), 64'd1);
      check({name, "/data"}, out_data, exp);
      check({name, "/tag"}, 64'(out_tag), 64'(tag));
      tick();
      check({name, "/drain"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_op     = '0;
      in_tag    = '0;
      out_ready = 1'b1;
`ifdef SHIFTER_WORD_OP_EN
      in_word   = 1'b0;
`endif

      // Reset state
      #2 rst_n = 1'b0;
      #2;
      check("rst/out_valid", 64'(out_valid), 64'd0);
      check("rst/out_data", out_data, 64'd0);
      check("rst/out_tag", 64'(out_tag), 64'd0);
      check("rst/in_ready", 64'(in_ready), 64'd1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Single ops, hand-computed results
      single("sra4",   64'h8000_0000_0000_0010, 6'd4,  2'b10, 4'h5, 64'hF800_0000_0000_0001);
      single("sll63",  64'h1,                   6'd63, 2'b00, 4'h1, 64'h8000_0000_0000_0000);
      single("ror1",   64'h1,                   6'd1,  2'b11, 4'h2, 64'h8000_0000_0000_0000);
      single("srl0",   64'hDEAD_BEEF_1234_5678, 6'd0,  2'b01, 4'h3, 64'hDEAD_BEEF_1234_5678);
      single("srl4",   64'hF000_0000_0000_0000, 6'd4,  2'b01, 4'h4, 64'h0F00_0000_0000_0000);
      single("sra60p", 64'h7000_0000_0000_0000, 6'd60, 2'b10, 4'h6, 64'h0000_0000_0000_0007);
      single("ror8",   64'h0000_0000_0000_00AB, 6'd8,  2'b11, 4'h7, 64'hAB00_0000_0000_0000);
      single("sll4",   64'h0123_4567_89AB_CDEF, 6'd4,  2'b00, 4'h8, 64'h1234_5678_9ABC_DEF0);
      single("sra63",  64'h8000_0000_0000_0000, 6'd63, 2'b10, 4'h9, 64'hFFFF_FFFF_FFFF_FFFF);
      single("ror32",  64'h1234_5678_9ABC_DEF0, 6'd32, 2'b11, 4'hA, 64'h9ABC_DEF0_1234_5678);
      single("sra0",   64'h8000_0000_0000_0001, 6'd0,  2'b10, 4'hB, 64'h8000_0000_0000_0001);
      single("ror0",   64'h8000_0000_0000_0001, 6'd0,  2'b11, 4'hC, 64'h8000_0000_0000_0001);
`ifdef SHIFTER_WORD_OP_EN
      in_word = 1'b1;
      single("w_sra36", 64'h0000_0000_8000_0000, 6'd36, 2'b10, 4'hD, 64'hFFFF_FFFF_F800_0000);
      single("w_sll31", 64'h1,                   6'd31, 2'b00, 4'hE, 64'hFFFF_FFFF_8000_0000);
      in_word = 1'b0;
`endif

      // Back-pressure: (k+1) << k for k = 0..7
      bp_exp[0] = 64'd1;   bp_exp[1] = 64'd4;   bp_exp[2] = 64'd12;  bp_exp[3] = 64'd32;
      bp_exp[4] = 64'd80;  bp_exp[5] = 64'd192; bp_exp[6] = 64'd448; bp_exp[7] = 64'd1024;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(64'(k + 1), 6'(k), 2'b00, 4'(k));
         #1;
         check("bp/accept", 64'(in_ready), 64'd1);
         tick();
      end
      drive(64'd4, 6'd3, 2'b00, 4'd3);
      #1;
      check("bp/full_ready", 64'(in_ready), 64'd0);
      check("bp/full_valid", 64'(out_valid), 64'd1);
      check("bp/full_data", out_data, bp_exp[0]);
      for (int c = 0; c < 2; c++) begin
         tick();
         check("bp/stall_ready", 64'(in_ready), 64'd0);
         check("bp/hold_data", out_data, bp_exp[0]);
         check("bp/hold_tag", 64'(out_tag), 64'd0);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c + 3 < 8) drive(64'(c + 4), 6'(c + 3), 2'b00, 4'(c + 3));
         else           in_valid = 1'b0;
         #1;
         if (c + 3 < 8) check("bp/stream_ready", 64'(in_ready), 64'd1);
         check("bp/stream_valid", 64'(out_valid), 64'd1);
         check("bp/stream_data", out_data, bp_exp[c]);
         check("bp/stream_tag", 64'(out_tag), 64'(c));
         tick();
      end
      check("bp/empty", 64'(out_valid), 64'd0);

      // Reset with two ops in flight
      drive(64'hFFFF_0000_FFFF_0000, 6'd1, 2'b01, 4'h1);
      #1;
      tick();
      drive(64'h1234, 6'd2, 2'b00, 4'h2);
      #1;
      tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst/out_valid", 64'(out_valid), 64'd0);
      check("midrst/in_ready", 64'(in_ready), 64'd1);
      check("midrst/out_data", out_data, 64'd0);
      check("midrst/out_tag", 64'(out_tag), 64'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("midrst/held", 64'(out_valid), 64'd0);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("midrst/no_stale", 64'(out_valid), 64'd0);
      end

      // Random traffic with random back-pressure against the reference
      begin
         int sent;
         sent = 0;
         for (int cyc = 0; cyc < 4000; cyc++) begin
            if (sent == 400 && exp_d.size() == 0) break;
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 400 && $urandom_range(0, 3) != 0)
               drive({$urandom, $urandom}, 6'($urandom_range(0, 63)),
                     2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            else
               in_valid = 1'b0;
            #1;
            if (out_valid && out_ready) begin
               if (exp_d.size() == 0) begin
                  check("rnd/unexpected", 64'(out_valid), 64'd0);
               end else begin
                  check("rnd/data", out_data, exp_d.pop_front());
                  check("rnd/tag", 64'(out_tag), 64'(exp_t.pop_front()));
               end
            end
            if (in_valid && in_ready) begin
               exp_d.push_back(ref_shift(in_data, in_shamt, in_op));
               exp_t.push_back(in_tag);
               sent++;
            end
            tick();
         end
         in_valid = 1'b0;
         check("rnd/sent", 64'(sent), 64'd400);
         check("rnd/drained", 64'(exp_d.size()), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
